// File: rtl/obi_pkg.sv
// Shared types and constants for the two-master OBI arbiter.
package obi_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  typedef logic [$clog2(NUM_MASTERS)-1:0] mst_idx_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic mst_idx_t other_master(input mst_idx_t idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// Response-routing FIFO: remembers which master owns each outstanding transaction.
module obi_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [CntW-1:0] CntOne = 1;

  logic [DEPTH-1:0] r_mem;
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CntW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign data_o  = r_mem[r_rptr];

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt order.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= r_wptr + PtrOne;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrOne;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/obi_arbiter.sv
// Two-master OBI arbiter with round-robin selection, owner lock while the slave stalls,
// and in-order response routing back to the issuing master.
module obi_arbiter
  import obi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rstn_i,
  input  logic [NUM_MASTERS-1:0]                   m_req_i,
  output logic [NUM_MASTERS-1:0]                   m_gnt_o,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0]                   m_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]                   m_rvalid_o,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_rdata_o,
  output logic                                     s_req_o,
  output logic [ADDR_WIDTH-1:0]                    s_addr_o,
  output logic                                     s_we_o,
  output logic [DATA_WIDTH/8-1:0]                  s_be_o,
  output logic [DATA_WIDTH-1:0]                    s_wdata_o,
  input  logic                                     s_gnt_i,
  input  logic                                     s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    s_rdata_i,
  output logic                                     err_o
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  mst_idx_t   r_owner;
  mst_idx_t   w_owner_nxt;
  mst_idx_t   r_rr_ptr;
  mst_idx_t   w_rr_ptr_nxt;
  logic       r_err;

  mst_idx_t   w_sel;
  logic       w_sel_vld;
  logic       w_accept;
  logic       w_full;
  logic       w_empty;
  logic       w_head;
  logic       w_pop;

  // Owner selection; the reset term keeps the address phase quiet while rstn_i is low.
  always_comb begin
    w_sel     = r_owner;
    w_sel_vld = 1'b0;
    if (r_state == LOCKED) begin
      w_sel     = r_owner;
      w_sel_vld = m_req_i[r_owner];
    end else begin
      unique case (m_req_i)
        2'b01: begin
          w_sel     = 1'b0;
          w_sel_vld = 1'b1;
        end
        2'b10: begin
          w_sel     = 1'b1;
          w_sel_vld = 1'b1;
        end
        2'b11: begin
          w_sel     = r_rr_ptr;
          w_sel_vld = 1'b1;
        end
        default: ;
      endcase
    end
    w_sel_vld = w_sel_vld & rstn_i;
  end

  assign s_req_o   = w_sel_vld & ~w_full;
  assign s_addr_o  = w_sel_vld ? m_addr_i[w_sel]  : '0;
  assign s_we_o    = w_sel_vld ? m_we_i[w_sel]    : 1'b0;
  assign s_be_o    = w_sel_vld ? m_be_i[w_sel]    : '0;
  assign s_wdata_o = w_sel_vld ? m_wdata_i[w_sel] : '0;
  assign w_accept  = s_req_o & s_gnt_i;

  always_comb begin
    m_gnt_o = '0;
    if (w_accept) begin
      m_gnt_o[w_sel] = 1'b1;
    end
  end

  // A full FIFO forces s_req_o low, so neither transition below can fire.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_accept) begin
      w_state_nxt  = ARB;
      w_rr_ptr_nxt = other_master(w_sel);
    end else if ((r_state == ARB) && s_req_o) begin
      w_state_nxt = LOCKED;
      w_owner_nxt = w_sel;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= ARB;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      if (s_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_o = r_err;
  assign w_pop = s_rvalid_i & ~w_empty;

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_accept),
    .data_i  (w_sel),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Response routing depends only on FIFO state and slave inputs.
  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    if (!w_empty) begin
      m_rvalid_o[w_head] = s_rvalid_i;
      m_rdata_o[w_head]  = s_rdata_i;
    end
  end

endmodule
